// File: rtl/demux_1_to_3.sv
// ---------------------------------------------------------------------------
// demux_1_to_3
//   Registered 1-to-3 demultiplexer. Steers one data word from the shared
//   load/data bus into one of three destination registers: IFM, weight or
//   bias. Each destination keeps its last written value until it is selected
//   again. sel == 2'b00 is idle and writes nothing.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset, clears all destinations
//   sel          destination select: IFM, WGT, BIAS, or 2'b00 for idle
//   main_input   data word to route
//   main_output  destination registers [0]=IFM, [1]=WGT, [2]=BIAS
// ---------------------------------------------------------------------------
module demux_1_to_3 #(
  parameter int unsigned INPUT_WIDTH  = 32,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter logic [1:0]  IFM          = 2'b01,
  parameter logic [1:0]  WGT          = 2'b10,
  parameter logic [1:0]  BIAS         = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              sel,
  input  logic [INPUT_WIDTH-1:0]  main_input,
  output logic [OUTPUT_WIDTH-1:0] main_output [2:0]
);

  // Input word adapted to the destination width: zero-extend when the
  // destination is wider, keep the low bits when it is narrower.
  logic [OUTPUT_WIDTH-1:0] data_fit;

  generate
    if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_extend
      assign data_fit = {{(OUTPUT_WIDTH - INPUT_WIDTH){1'b0}}, main_input};
    end else begin : g_truncate
      assign data_fit = main_input[OUTPUT_WIDTH-1:0];
    end
  endgenerate

  logic [OUTPUT_WIDTH-1:0] out_reg [2:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dest
      localparam logic [1:0] CODE = (gi == 0) ? IFM :
                                    (gi == 1) ? WGT : BIAS;

      logic wr_en;
      // Equality against the exact code: an X/Z bit on sel makes the
      // comparison non-true, so no destination is written.
      assign wr_en = (sel == CODE);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_reg[gi] <= '0;
        end else if (wr_en) begin
          out_reg[gi] <= data_fit;
        end
      end

      assign main_output[gi] = out_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_demux_1_to_3.sv
module tb_demux_1_to_3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [31:0] main_input;
  logic [31:0] main_output [2:0];

  int total = 0;
  int bad   = 0;

  // Reference: the current content of each destination, indexed 0..2.
  logic [31:0] ref_mem [3];

  demux_1_to_3 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .main_input  (main_input),
    .main_output (main_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s.out%0d", tag, i), main_output[i], ref_mem[i]);
  endtask

  // Drive one transaction at the falling edge, let one rising edge pass,
  // then compare at the next falling edge.
  task automatic apply(input logic [1:0] s, input logic [31:0] d, input string tag);
    sel        = s;
    main_input = d;
    if (s != 2'd0) ref_mem[s - 1] = d;  // codes 1..3 map to index 0..2
    @(posedge clk);
    @(negedge clk);
    $display("txn %s sel=%0d data=%0d out=%0d/%0d/%0d", tag, s, d,
             main_output[0], main_output[1], main_output[2]);
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) ref_mem[i] = '0;
    rst_n      = 1'b0;
    sel        = 'x;
    main_input = 'x;

    // Reset held with sel/data unknown.
    #10;
    check_all("reset_hold");
    #10;               // t=20, falling edge: release
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all("post_release_selx");

    // Single routes.
    apply(2'd1, 32'd15, "route_ifm");
    apply(2'd3, 32'd15, "route_bias");
    apply(2'd2, 32'd15, "route_wgt");
    // Overwrite.
    apply(2'd3, 32'd90, "ovw_bias");
    apply(2'd1, 32'd90, "ovw_ifm");
    // Mixed.
    apply(2'd2, 32'd40, "mix_wgt");
    apply(2'd1, 32'd40, "mix_ifm");
    // Idle and hold.
    for (int i = 0; i < 4; i++) apply(2'd0, 32'd123, "idle");

    // Randomized traffic, including idle cycles and extreme data values.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFFF;
        1:       d = $urandom_range(1, 255);
        default: d = $urandom;
      endcase
      apply(2'($urandom_range(0, 3)), d, "rand");
    end

    // Make sure every destination is nonzero before the async clear.
    apply(2'd1, 32'hA5A5_0001, "pre_rst_ifm");
    apply(2'd2, 32'h5A5A_0002, "pre_rst_wgt");
    apply(2'd3, 32'hDEAD_BEEF, "pre_rst_bias");

    // Asynchronous reset between edges; must clear before the next edge.
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) ref_mem[i] = '0;
    #1;
    check_all("async_clear");
    // Writes are blocked while reset is held.
    sel        = 2'd2;
    main_input = 32'd77;
    @(posedge clk);
    @(negedge clk);
    check_all("rst_blocks_write");
    rst_n = 1'b1;
    apply(2'd2, 32'd77, "after_rst_wgt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
